// File: rtl/i2c_sda_shifter_if.sv
// Byte-level command/result bundle between the I2C master FSM and the SDA shifter.
// The master modport belongs to the FSM and the slave modport to i2c_sda_shifter.
interface i2c_sda_shifter_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] tx_data;
  logic       send_ack;
  logic [7:0] rx_data;
  logic       ack_rcvd;
  logic       arb_lost;
  logic       done;

  modport master (
    output cmd_valid, cmd, tx_data, send_ack,
    input  cmd_ready, rx_data, ack_rcvd, arb_lost, done
  );

  modport slave (
    input  cmd_valid, cmd, tx_data, send_ack,
    output cmd_ready, rx_data, ack_rcvd, arb_lost, done
  );
endinterface

// File: rtl/i2c_sda_shifter.sv
// SDA data path of the I2C master: START/STOP forming, byte transmit with ACK sampling,
// byte receive with ACK/NACK drive. Bit timing follows scl_generate's count_ctrl.
module i2c_sda_shifter #(
    parameter int unsigned T_LOW           = 6,
    parameter int unsigned T_HIGH          = 4,
    parameter int unsigned SETUP_SCL_START = 4,
    parameter int unsigned DATA_LEN        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_sda_shifter_if.slave      bus,
    input  logic [6:0]            count_ctrl,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [3:0]            bit_count
);

    localparam logic [6:0] DRV     = 7'(T_LOW / 2);
    localparam logic [6:0] SMP     = 7'(T_LOW + T_HIGH / 2);
    localparam logic [6:0] FEND    = 7'(T_LOW + T_HIGH - 1);
    localparam logic [6:0] ST_FALL = 7'(SETUP_SCL_START / 2);
    localparam logic [6:0] ST_END  = 7'(SETUP_SCL_START - 1);
    localparam logic [3:0] LAST    = 4'(DATA_LEN - 1);

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_TX_BIT, S_TX_ACK, S_RX_BIT, S_RX_ACK, S_STOP
    } state_e;

    state_e     state, state_n;
    logic       sda_oe_n;
    logic [7:0] shift, shift_n;
    logic [3:0] bit_count_n;
    logic [7:0] rx_data, rx_data_n;
    logic       ack_rcvd, ack_rcvd_n;
    logic       ack_sel, ack_sel_n;
    logic       arb_lost, arb_lost_n;
    logic       done, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            sda_oe    <= 1'b0;
            shift     <= '0;
            bit_count <= '0;
            rx_data   <= '0;
            ack_rcvd  <= 1'b0;
            ack_sel   <= 1'b0;
            arb_lost  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            sda_oe    <= sda_oe_n;
            shift     <= shift_n;
            bit_count <= bit_count_n;
            rx_data   <= rx_data_n;
            ack_rcvd  <= ack_rcvd_n;
            ack_sel   <= ack_sel_n;
            arb_lost  <= arb_lost_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        sda_oe_n    = sda_oe;
        shift_n     = shift;
        bit_count_n = bit_count;
        rx_data_n   = rx_data;
        ack_rcvd_n  = ack_rcvd;
        ack_sel_n   = ack_sel;
        arb_lost_n  = 1'b0;
        done_n      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    bit_count_n = '0;
                    unique case (cmd_e'(bus.cmd))
                        CMD_START: state_n = S_START;
                        CMD_WRITE: begin
                            shift_n    = bus.tx_data;
                            ack_rcvd_n = 1'b0;
                            state_n    = S_TX_BIT;
                        end
                        CMD_READ: begin
                            shift_n   = '0;
                            ack_sel_n = bus.send_ack;
                            state_n   = S_RX_BIT;
                        end
                        CMD_STOP: state_n = S_STOP;
                    endcase
                end
            end

            S_START: begin
                if (count_ctrl == ST_FALL) sda_oe_n = 1'b1;
                if (count_ctrl == ST_END) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end

            S_TX_BIT: begin
                if (count_ctrl == DRV) sda_oe_n = ~shift[7];
                // A released '1' seen low means another master owns the bus; back off silently.
                if (count_ctrl == SMP && !sda_oe && !sda_i) begin
                    arb_lost_n  = 1'b1;
                    sda_oe_n    = 1'b0;
                    bit_count_n = '0;
                    state_n     = S_IDLE;
                end
                if (count_ctrl == FEND) begin
                    shift_n     = {shift[6:0], 1'b0};
                    bit_count_n = bit_count + 4'd1;
                    if (bit_count == LAST) state_n = S_TX_ACK;
                end
            end

            S_TX_ACK: begin
                if (count_ctrl == DRV) sda_oe_n = 1'b0;
                if (count_ctrl == SMP) ack_rcvd_n = ~sda_i;
                if (count_ctrl == FEND) begin
                    bit_count_n = '0;
                    state_n     = S_IDLE;
                    done_n      = 1'b1;
                end
            end

            S_RX_BIT: begin
                if (count_ctrl == DRV) sda_oe_n = 1'b0;
                if (count_ctrl == SMP) shift_n = {shift[6:0], sda_i};
                if (count_ctrl == FEND) begin
                    bit_count_n = bit_count + 4'd1;
                    if (bit_count == LAST) begin
                        rx_data_n = shift;
                        state_n   = S_RX_ACK;
                    end
                end
            end

            S_RX_ACK: begin
                if (count_ctrl == DRV) sda_oe_n = ack_sel;
                if (count_ctrl == FEND) begin
                    bit_count_n = '0;
                    state_n     = S_IDLE;
                    done_n      = 1'b1;
                end
            end

            S_STOP: begin
                if (count_ctrl == DRV) sda_oe_n = 1'b1;
                if (count_ctrl == SMP) sda_oe_n = 1'b0;
                if (count_ctrl == FEND) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.rx_data   = rx_data;
    assign bus.ack_rcvd  = ack_rcvd;
    assign bus.arb_lost  = arb_lost;
    assign bus.done      = done;

endmodule

// File: tb/tb_i2c_sda_shifter.sv
// Directed bench for i2c_sda_shifter: models scl_generate's frame counter and an
// open-drain slave on SDA, and checks each command's timing and line behaviour.
module tb_i2c_sda_shifter;

    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_WRITE = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_STOP  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] count_ctrl = '0;
    logic       sda_oe;
    logic       sda_i;
    logic       slave_pull = 1'b0;
    logic [3:0] bit_count;

    int errors = 0;
    int checks = 0;

    int         lat;
    logic       arb;
    logic [7:0] oe_bits;
    logic       oe_f0c9;
    logic       oe_ack;
    logic       ready_busy;

    i2c_sda_shifter_if bus ();

    i2c_sda_shifter #(
        .T_LOW(6), .T_HIGH(4), .SETUP_SCL_START(4), .DATA_LEN(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .count_ctrl(count_ctrl),
        .sda_i(sda_i),
        .sda_oe(sda_oe),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    // Open-drain line: low if either side pulls.
    assign sda_i = ~(sda_oe | slave_pull);

    // Frame counter of scl_generate, restarted by rst_count on accept.
    always @(posedge clk) begin
        if (bus.cmd_valid && bus.cmd_ready) count_ctrl <= '0;
        else if (count_ctrl == 7'd9)        count_ctrl <= '0;
        else                                count_ctrl <= count_ctrl + 7'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic sa);
        @(negedge clk);
        bus.cmd       = c;
        bus.tx_data   = d;
        bus.send_ack  = sa;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Starts right after the accept edge (n=0 is cycle A+1); stops at done or arb_lost.
    task automatic run_body(input logic [1:0] c, input logic [7:0] sbyte, input logic sack,
                            input int pull_frame,
                            output int o_lat, output logic o_arb, output logic [7:0] o_oe_bits,
                            output logic o_f0c9, output logic o_ack, output logic o_rdy);
        o_lat = -1; o_arb = 1'b0; o_oe_bits = '0; o_f0c9 = 1'b0; o_ack = 1'b0; o_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            int frame;
            int cnt;
            frame = n / 10;
            cnt   = n % 10;
            if (c == C_READ && frame < 8)       slave_pull = ~sbyte[7 - frame];
            else if (c == C_WRITE && frame == 8) slave_pull = sack;
            else if (frame == pull_frame)        slave_pull = 1'b1;
            else                                 slave_pull = 1'b0;
            if (cnt == 4 && frame < 8)    o_oe_bits[7 - frame] = sda_oe;
            if (frame == 0 && cnt == 9)   o_f0c9 = sda_oe;
            if (frame == 8 && cnt == 9)   o_ack = sda_oe;
            if (n == 1)                   o_rdy = bus.cmd_ready;
            if (bus.done || bus.arb_lost) begin
                o_lat = n;
                o_arb = bus.arb_lost;
                break;
            end
            @(posedge clk);
            #1;
        end
        slave_pull = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd       = C_START;
        bus.tx_data   = '0;
        bus.send_ack  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sda_oe",    32'(sda_oe),        32'd0);
        check("rst_bit_count", 32'(bit_count),     32'd0);
        check("rst_rx_data",   32'(bus.rx_data),   32'd0);
        check("rst_ack_rcvd",  32'(bus.ack_rcvd),  32'd0);
        check("rst_arb_lost",  32'(bus.arb_lost),  32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 1: reset in the middle of a WRITE, bit 4
        issue(C_WRITE, 8'h00, 1'b0);
        repeat (44) @(posedge clk);
        #1;
        check("t1_bitcount_mid", 32'(bit_count), 32'd4);
        check("t1_sda_oe_mid",   32'(sda_oe),    32'd1);
        rst = 1'b1;
        #1;
        check("t1_sda_oe_rst",   32'(sda_oe),    32'd0);
        check("t1_done_rst",     32'(bus.done),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t1_ready_after",  32'(bus.cmd_ready), 32'd1);
        check("t1_bitcount_after", 32'(bit_count),   32'd0);

        // 2: START then WRITE 0xA5 with slave ACK
        issue(C_START, 8'h00, 1'b0);
        run_body(C_START, 8'h00, 1'b0, -1, lat, arb, oe_bits, oe_f0c9, oe_ack, ready_busy);
        check("t2_start_lat",    32'(lat),        32'd4);
        check("t2_start_busy",   32'(ready_busy), 32'd0);
        check("t2_start_oe",     32'(sda_oe),     32'd1);
        issue(C_WRITE, 8'hA5, 1'b0);
        run_body(C_WRITE, 8'h00, 1'b1, -1, lat, arb, oe_bits, oe_f0c9, oe_ack, ready_busy);
        check("t2_wr_lat",       32'(lat),          32'd90);
        check("t2_wr_oe_bits",   32'(oe_bits),      32'h5A);
        check("t2_wr_ack_rcvd",  32'(bus.ack_rcvd), 32'd1);
        check("t2_wr_arb",       32'(arb),          32'd0);
        check("t2_wr_bitcount",  32'(bit_count),    32'd0);

        // 3: READ 0x3C, NACK
        issue(C_READ, 8'h00, 1'b0);
        run_body(C_READ, 8'h3C, 1'b0, -1, lat, arb, oe_bits, oe_f0c9, oe_ack, ready_busy);
        check("t3_rd_lat",       32'(lat),         32'd90);
        check("t3_rd_data",      32'(bus.rx_data), 32'h3C);
        check("t3_rd_oe_ack",    32'(oe_ack),      32'd0);
        check("t3_rd_oe_bits",   32'(oe_bits),     32'h00);

        // 4: WRITE 0x80, SDA held low while the first ('1') bit is released
        issue(C_WRITE, 8'h80, 1'b0);
        run_body(C_WRITE, 8'h00, 1'b0, 0, lat, arb, oe_bits, oe_f0c9, oe_ack, ready_busy);
        check("t4_arb",          32'(arb),           32'd1);
        check("t4_arb_lat",      32'(lat),           32'd9);
        check("t4_sda_oe",       32'(sda_oe),        32'd0);
        check("t4_ready",        32'(bus.cmd_ready), 32'd1);
        check("t4_no_done",      32'(bus.done),      32'd0);
        @(posedge clk);
        #1;
        check("t4_arb_pulse",    32'(bus.arb_lost),  32'd0);
        check("t4_no_done_next", 32'(bus.done),      32'd0);

        // 5: STOP
        issue(C_STOP, 8'h00, 1'b0);
        run_body(C_STOP, 8'h00, 1'b0, -1, lat, arb, oe_bits, oe_f0c9, oe_ack, ready_busy);
        check("t5_stop_lat",     32'(lat),        32'd10);
        check("t5_stop_oe_drv",  32'(oe_bits[7]), 32'd1);
        check("t5_stop_oe_smp",  32'(oe_f0c9),    32'd0);
        check("t5_stop_oe_done", 32'(sda_oe),     32'd0);

        // 6: WRITE held valid during a READ (ACK), accepted in the done cycle
        issue(C_READ, 8'h00, 1'b1);
        bus.cmd       = C_WRITE;
        bus.tx_data   = 8'h5A;
        bus.cmd_valid = 1'b1;
        run_body(C_READ, 8'hC3, 1'b0, -1, lat, arb, oe_bits, oe_f0c9, oe_ack, ready_busy);
        check("t6_rd_lat",       32'(lat),         32'd90);
        check("t6_rd_busy",      32'(ready_busy),  32'd0);
        check("t6_rd_data",      32'(bus.rx_data), 32'hC3);
        check("t6_rd_oe_ack",    32'(oe_ack),      32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("t6_wr_accepted",  32'(bus.cmd_ready), 32'd0);
        run_body(C_WRITE, 8'h00, 1'b0, -1, lat, arb, oe_bits, oe_f0c9, oe_ack, ready_busy);
        check("t6_wr_lat",       32'(lat),          32'd90);
        check("t6_wr_oe_bits",   32'(oe_bits),      32'hA5);
        check("t6_wr_ack_rcvd",  32'(bus.ack_rcvd), 32'd0);
        check("t6_rx_held",      32'(bus.rx_data),  32'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
